// File: rtl/fp_issue_scheduler_pkg.sv
// Shared pipe-select encoding and default pipe latencies for the issue scheduler.
package fp_issue_scheduler_pkg;

    typedef enum logic [1:0] {
        PIPE_INT   = 2'd0,
        PIPE_MEM   = 2'd1,
        PIPE_FLOAT = 2'd2,
        PIPE_RSVD  = 2'd3
    } pipe_e;

    localparam int INT_LAT = 1;
    localparam int MEM_LAT = 4;
    localparam int FP_LAT  = 5;

endpackage

// File: rtl/fp_issue_scheduler_rr_arbiter.sv
// Round-robin arbiter: the search starts just after the last granted index.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 update_lru,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] gnt_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] last;
    logic [IW-1:0] idx;
    logic          found;

    // N is a power of two, so IW-bit addition wraps modulo N for free
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N; i++) begin
            idx = last + IW'(i);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            last <= IW'(N - 1);
        else if (update_lru && found)
            last <= gnt_idx;
    end

endmodule

// File: rtl/fp_issue_scheduler.sv
// Single-issue scheduler with a shared writeback-slot reservation vector.
// Optional FP_ISSUE_PERF_EN adds conflict-pulse and saturating issue counters.
module fp_issue_scheduler
    import fp_issue_scheduler_pkg::*;
#(
    parameter int NUM_THREADS = 4,
    parameter int INT_LATENCY = INT_LAT,
    parameter int MEM_LATENCY = MEM_LAT,
    parameter int FP_LATENCY  = FP_LAT
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_THREADS-1:0]         req_valid,
    input  logic [NUM_THREADS-1:0][1:0]    req_pipe,
    input  logic                           issue_stall,
    output logic [NUM_THREADS-1:0]         grant_oh,
    output logic                           grant_valid,
    output logic [$clog2(NUM_THREADS)-1:0] grant_idx,
    output logic [1:0]                     grant_pipe,
    output logic [FP_LATENCY:0]            wb_busy
`ifdef FP_ISSUE_PERF_EN
    ,
    output logic                           perf_wb_conflict,
    output logic [31:0]                    perf_issue_count
`endif
);

    localparam int WBW = FP_LATENCY + 1;
    localparam int LW  = $clog2(WBW);

    function automatic logic [LW-1:0] lat_of(input logic [1:0] p);
        case (p)
            PIPE_INT:   lat_of = LW'(INT_LATENCY);
            PIPE_MEM:   lat_of = LW'(MEM_LATENCY);
            PIPE_FLOAT: lat_of = LW'(FP_LATENCY);
            default:    lat_of = '0;
        endcase
    endfunction

    logic [NUM_THREADS-1:0] live, slot_free, elig;
    logic [LW-1:0]          g_lat;
    logic [WBW-1:0]         wb_inc;

    for (genvar t = 0; t < NUM_THREADS; t++) begin : g_thr
        assign live[t]      = req_valid[t] && (req_pipe[t] != PIPE_RSVD);
        assign slot_free[t] = !wb_busy[lat_of(req_pipe[t])];
        assign elig[t]      = live[t] && slot_free[t] && !issue_stall;
    end

    rr_arbiter #(.N(NUM_THREADS)) u_arb (
        .clk        (clk),
        .reset      (reset),
        .req        (elig),
        .update_lru (grant_valid),
        .gnt        (grant_oh),
        .gnt_idx    (grant_idx)
    );

    assign grant_valid = |grant_oh;
    assign grant_pipe  = grant_valid ? req_pipe[grant_idx] : 2'd0;
    assign g_lat       = lat_of(grant_pipe);
    // a grant at latency L lands in slot L-1 after this cycle's shift
    assign wb_inc      = grant_valid ? (WBW'(1) << (g_lat - LW'(1))) : '0;

    always_ff @(posedge clk) begin
        if (reset)
            wb_busy <= '0;
        else
            wb_busy <= (wb_busy >> 1) | wb_inc;
    end

`ifdef FP_ISSUE_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_wb_conflict <= 1'b0;
            perf_issue_count <= '0;
        end else begin
            perf_wb_conflict <= |(live & ~slot_free) && !issue_stall;
            if (grant_valid && perf_issue_count != 32'hFFFF_FFFF)
                perf_issue_count <= perf_issue_count + 32'd1;
        end
    end
`endif

    always @(posedge clk) begin
        assert (FP_LATENCY >= MEM_LATENCY && FP_LATENCY >= INT_LATENCY);
        if (!reset) begin
            assert ($onehot0(grant_oh));
            assert (!grant_valid || !wb_busy[g_lat]);
        end
    end

endmodule

// File: tb/tb_fp_issue_scheduler.sv
// Directed bench for fp_issue_scheduler: round-robin order, slot collisions, stall, reset.
module tb_fp_issue_scheduler;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_valid;
    logic [3:0][1:0] req_pipe;
    logic            issue_stall;
    logic [3:0]      grant_oh;
    logic            grant_valid;
    logic [1:0]      grant_idx;
    logic [1:0]      grant_pipe;
    logic [5:0]      wb_busy;
`ifdef FP_ISSUE_PERF_EN
    logic            perf_wb_conflict;
    logic [31:0]     perf_issue_count;
`endif

    int pass_cnt = 0;
    int total    = 0;

    fp_issue_scheduler #(.NUM_THREADS(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_pipe    (req_pipe),
        .issue_stall (issue_stall),
        .grant_oh    (grant_oh),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_pipe  (grant_pipe),
        .wb_busy     (wb_busy)
`ifdef FP_ISSUE_PERF_EN
        ,
        .perf_wb_conflict (perf_wb_conflict),
        .perf_issue_count (perf_issue_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        req_pipe  = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic test_reset();
        reset = 1'b1; issue_stall = 1'b0; req_valid = '0; req_pipe = '0;
        step(); step();
        reset = 1'b0;
        #1;
        total++;
        if (wb_busy !== 6'b0) $display("FAIL reset_wb_busy got %b want %b", wb_busy, 6'b0);
        else pass_cnt++;
        total++;
        if (grant_valid !== 1'b0 || grant_oh !== 4'b0)
            $display("FAIL reset_grant got %b/%b want 0/0000", grant_valid, grant_oh);
        else pass_cnt++;
    endtask

    task automatic test_rr_int();
        logic [1:0] exp_idx [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        logic [5:0] exp_wb;
        req_valid = 4'b1111; req_pipe = '0;
        for (int i = 0; i < 5; i++) begin
            exp_wb = (i == 0) ? 6'b000000 : 6'b000001;
            #1;
            total++;
            if (grant_valid !== 1'b1 || grant_idx !== exp_idx[i] || grant_oh !== (4'b1 << exp_idx[i]))
                $display("FAIL rr_int_%0d got v=%b idx=%0d oh=%b want idx=%0d", i, grant_valid, grant_idx, grant_oh, exp_idx[i]);
            else pass_cnt++;
            total++;
            if (wb_busy !== exp_wb) $display("FAIL rr_int_wb_%0d got %b want %b", i, wb_busy, exp_wb);
            else pass_cnt++;
            step();
        end
        idle(6);
    endtask

    task automatic test_fp_then_int();
        // rr_last = 0: the lone FP request on thread 0 is granted
        req_valid = 4'b0001; req_pipe[0] = 2'd2;
        #1;
        total++;
        if (grant_idx !== 2'd0 || grant_pipe !== 2'd2 || grant_valid !== 1'b1)
            $display("FAIL fp_grant got v=%b idx=%0d pipe=%0d want 1/0/2", grant_valid, grant_idx, grant_pipe);
        else pass_cnt++;
        step();
        total++;
        if (wb_busy !== 6'b010000) $display("FAIL fp_wb got %b want %b", wb_busy, 6'b010000);
        else pass_cnt++;
        req_valid = '0; req_pipe = '0;
        step(); step();
        req_valid = 4'b0010; req_pipe[1] = 2'd0;
        #1;
        total++;
        if (wb_busy !== 6'b000100 || grant_valid !== 1'b1 || grant_idx !== 2'd1)
            $display("FAIL int_first got wb=%b v=%b idx=%0d want 000100/1/1", wb_busy, grant_valid, grant_idx);
        else pass_cnt++;
        step();
        total++;
        if (wb_busy !== 6'b000011 || grant_valid !== 1'b0)
            $display("FAIL int_blocked got wb=%b v=%b want 000011/0", wb_busy, grant_valid);
        else pass_cnt++;
        step();
        total++;
        if (wb_busy !== 6'b000001 || grant_valid !== 1'b1 || grant_idx !== 2'd1)
            $display("FAIL int_retry got wb=%b v=%b idx=%0d want 000001/1/1", wb_busy, grant_valid, grant_idx);
        else pass_cnt++;
        step();
        idle(6);
    endtask

    task automatic test_mem_vs_fp();
        // rr_last = 1: thread 3 FP granted
        req_valid = 4'b1000; req_pipe[3] = 2'd2;
        #1;
        total++;
        if (grant_idx !== 2'd3 || grant_valid !== 1'b1)
            $display("FAIL fp3_grant got v=%b idx=%0d want 1/3", grant_valid, grant_idx);
        else pass_cnt++;
        step();
        req_valid = 4'b0100; req_pipe = '0; req_pipe[2] = 2'd1;
        #1;
        total++;
        if (wb_busy !== 6'b010000 || grant_valid !== 1'b0)
            $display("FAIL mem_blocked got wb=%b v=%b want 010000/0", wb_busy, grant_valid);
        else pass_cnt++;
        step();
        total++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd2 || grant_pipe !== 2'd1)
            $display("FAIL mem_grant got v=%b idx=%0d pipe=%0d want 1/2/1", grant_valid, grant_idx, grant_pipe);
        else pass_cnt++;
        step();
        total++;
        if (wb_busy !== 6'b001100) $display("FAIL mem_wb got %b want %b", wb_busy, 6'b001100);
        else pass_cnt++;
        idle(6);
    endtask

    task automatic test_stall();
        logic [5:0] exp_wb [3] = '{6'b010000, 6'b001000, 6'b000100};
        // rr_last = 2: thread 0 FP granted, pointer moves to 0
        req_valid = 4'b0001; req_pipe[0] = 2'd2;
        step();
        req_valid = 4'b1111; req_pipe = {2'd1, 2'd1, 2'd1, 2'd1};
        issue_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (grant_valid !== 1'b0 || grant_oh !== 4'b0 || wb_busy !== exp_wb[i])
                $display("FAIL stall_%0d got v=%b oh=%b wb=%b want 0/0000/%b", i, grant_valid, grant_oh, wb_busy, exp_wb[i]);
            else pass_cnt++;
            step();
        end
        issue_stall = 1'b0;
        #1;
        total++;
        if (wb_busy !== 6'b000010 || grant_valid !== 1'b1 || grant_idx !== 2'd1)
            $display("FAIL stall_release got wb=%b v=%b idx=%0d want 000010/1/1", wb_busy, grant_valid, grant_idx);
        else pass_cnt++;
        step();
        idle(6);
    endtask

    task automatic test_reserved();
        req_valid = 4'b0010; req_pipe[1] = 2'd3;
        #1;
        total++;
        if (grant_valid !== 1'b0 || grant_oh !== 4'b0)
            $display("FAIL reserved_only got v=%b oh=%b want 0/0000", grant_valid, grant_oh);
        else pass_cnt++;
        // rr_last = 1: search 2,3,0,1; thread 2 is idle so thread 3 wins
        req_valid = 4'b1010; req_pipe[3] = 2'd0;
        #1;
        total++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd3)
            $display("FAIL reserved_skip got v=%b idx=%0d want 1/3", grant_valid, grant_idx);
        else pass_cnt++;
        step();
        idle(3);
    endtask

    task automatic test_reset_mid();
        // rr_last = 3: thread 0 FP granted
        req_valid = 4'b0001; req_pipe[0] = 2'd2;
        step();
        total++;
        if (wb_busy !== 6'b010000) $display("FAIL pre_reset_wb got %b want %b", wb_busy, 6'b010000);
        else pass_cnt++;
        reset = 1'b1; req_valid = '0; req_pipe = '0;
        step();
        reset = 1'b0;
        #1;
        total++;
        if (wb_busy !== 6'b0) $display("FAIL mid_reset_wb got %b want %b", wb_busy, 6'b0);
        else pass_cnt++;
`ifdef FP_ISSUE_PERF_EN
        total++;
        if (perf_wb_conflict !== 1'b0 || perf_issue_count !== 32'd0)
            $display("FAIL perf_reset got %b/%0d want 0/0", perf_wb_conflict, perf_issue_count);
        else pass_cnt++;
`endif
        // pointer back to NUM_THREADS-1, so thread 0 is searched first
        req_valid = 4'b1111;
        #1;
        total++;
        if (grant_valid !== 1'b1 || grant_idx !== 2'd0)
            $display("FAIL reset_ptr got v=%b idx=%0d want 1/0", grant_valid, grant_idx);
        else pass_cnt++;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_rr_int();
        test_fp_then_int();
        test_mem_vs_fp();
        test_stall();
        test_reserved();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/fp_issue_scheduler.md
Name: fp_issue_scheduler

Overview:
- Per-cycle issue scheduler that selects one ready thread to issue into the execution pipelines.
- The integer (latency 1), memory (latency 4) and floating-point (latency 5) pipelines share a single register-file writeback port.
- The scheduler keeps a writeback-slot reservation vector so no two issued instructions write back in the same cycle.
- Arbitration is round-robin among eligible threads. The block sits between the thread-select logic and operand fetch.

Parameters:
- NUM_THREADS, 4, number of requesting hardware threads (power of two, 2..8).
- INT_LATENCY, 1, issue-to-writeback cycles for the integer pipe.
- MEM_LATENCY, 4, issue-to-writeback cycles for the memory pipe.
- FP_LATENCY, 5, issue-to-writeback cycles for the floating-point pipe; must be the maximum of the three.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_THREADS  thread t has an instruction ready.
- req_pipe  in  NUM_THREADS x 2  target pipe per thread: 0 = INT, 1 = MEM, 2 = FP, 3 = reserved (never eligible).
- issue_stall  in  1  downstream stall; no grant this cycle, reservations still age.
- grant_oh  out  NUM_THREADS  one-hot grant, combinational.
- grant_valid  out  1  OR of grant_oh.
- grant_idx  out  $clog2(NUM_THREADS)  index of the granted thread.
- grant_pipe  out  2  req_pipe of the granted thread.
- wb_busy  out  FP_LATENCY+1  current reservation vector, registered.

Behaviour:
- Reservation vector, wb_busy[k]:
  - Bit k set means a writeback is booked k cycles from the current cycle.
  - Bit 0 marks the writeback happening this cycle.
- Eligibility: thread t is eligible iff all of the following hold:
  - req_valid[t] is set;
  - req_pipe[t] is not 3;
  - wb_busy[L(t)] == 0, where L(t) is the latency for req_pipe[t];
  - issue_stall is low.
- Arbitration:
  - Round-robin pointer rr_last, registered.
  - Search order is rr_last+1, rr_last+2, … with wrap modulo NUM_THREADS; the first eligible thread is granted.
  - Grant is combinational, so there is zero-cycle latency from request to grant.
- Sequential update at each posedge clk:
  - wb_busy <= (wb_busy >> 1) | (grant_valid ? (1 << (L(granted) - 1)) : 0).
  - If grant_valid, rr_last <= grant_idx; otherwise rr_last holds.
- Simultaneous events:
  - At most one grant per cycle.
  - A lower-latency request never blocks on a higher-latency one; slots are checked independently.
  - Example: an FP grant at cycle t followed by an INT request at t+4 collides (both write back at t+5), so the INT request is blocked one cycle.
- Stall: while issue_stall is high, grant_oh = 0, the vector still shifts and the pointer holds.
- Reset:
  - wb_busy = 0.
  - rr_last = NUM_THREADS-1, so thread 0 is searched first.
  - The grant outputs are 0 because they are combinational from the zeroed state.
  - Reset mid-operation discards all reservations; in-flight instructions are flushed by the core reset.
- Assertions, simulation only:
  - grant_oh is one-hot or zero.
  - A granted slot is never already set.
  - FP_LATENCY ≥ MEM_LATENCY and FP_LATENCY ≥ INT_LATENCY.

Optional Feature:
- Macro FP_ISSUE_PERF_EN.
- When defined, adds outputs perf_wb_conflict (1 bit) and perf_issue_count (32 bits), both registered and cleared on reset:
  - perf_wb_conflict pulses the cycle after any valid, non-stalled request was blocked only by a wb_busy slot.
  - perf_issue_count increments on each grant and saturates at 32'hFFFFFFFF.
- When undefined, these ports and the logic behind them are absent.

Decomposition:
- The pipe-select enum (PIPE_INT, PIPE_MEM, PIPE_FLOAT, reserved) and the latency constants go in the shared defines package.
- One sub-module, rr_arbiter: a parameterised round-robin arbiter with request vector, one-hot grant and update_lru input. It is reusable elsewhere.

Test Plan:
- Reset, then req_valid = 4'b1111 all INT -> grants in order 0,1,2,3,0 on consecutive cycles; wb_busy never has two bits colliding.
- Thread 0 FP granted at cycle 10; thread 1 INT requesting from cycle 13 -> granted at 13; at cycle 14 the thread 1 request is blocked (wb_busy[1] is set); granted at 15.
- Thread 2 MEM at cycle 20 and thread 3 FP at cycle 19 -> thread 3 granted at 19 (wb slot 24); at 20, MEM L=4 targets slot 24 and is blocked; MEM granted at 21.
- issue_stall high for 3 cycles with an FP reservation outstanding -> no grants; wb_busy shifts right 3 times; rr_last unchanged.
- req_pipe = 3 on thread 1 only -> no grant, grant_valid = 0.
- Reset asserted one cycle after an FP grant -> next cycle wb_busy = 0; with FP_ISSUE_PERF_EN, counters read 0.
